// File: rtl/modulo_controlador_bandeja_rolhas_pkg.sv
// Shared types and constants for the cork tray controller.
// Holds the FSM states, default line parameters and the saturating helper.
package pkg_bandeja_rolhas;

   localparam int unsigned LARGURA          = 7;
   localparam int unsigned LARGURA_SOMA     = 8;
   localparam int unsigned LARGURA_TEMP     = 4;

   localparam int unsigned CAP_PADRAO       = 99;
   localparam int unsigned MIN_NIVEL_PADRAO = 5;
   localparam int unsigned QTD_AUTO_PADRAO  = 20;
   localparam int unsigned TIMEOUT_PADRAO   = 15;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      VEDAR  = 2'd1,
      CARGA  = 2'd2,
      ESPERA = 2'd3
   } estado_e;

   // One-cycle grant responses towards the sealing stage and the operator.
   typedef struct packed {
      logic ack_vedacao;
      logic ack_carga;
      logic nack_carga;
   } respostas_t;

   // Clamp a wide sum to the tray capacity and narrow it to count width.
   function automatic logic [LARGURA-1:0] satura(
      input logic [LARGURA_SOMA-1:0] valor,
      input logic [LARGURA_SOMA-1:0] cap
   );
      return (valor > cap) ? LARGURA'(cap) : LARGURA'(valor);
   endfunction

endpackage

// File: rtl/modulo_controlador_bandeja_rolhas_temporizador.sv
// Dispenser handshake watchdog: counts cycles while a request is pending.
// estouro_c flags the edge on which the count reaches TIMEOUT.
module modulo_temporizador_dispensador
   import pkg_bandeja_rolhas::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_PADRAO
) (
   input  logic clk,
   input  logic Nclr,
   input  logic clr_i,
   input  logic en_i,
   output logic estouro_c
);

   localparam logic [LARGURA_TEMP-1:0] LIMITE = LARGURA_TEMP'(TIMEOUT - 1);

   logic [LARGURA_TEMP-1:0] cont_q;
   logic [LARGURA_TEMP-1:0] cont_d;

   always_comb begin
      cont_d = cont_q;
      if (clr_i) begin
         cont_d = '0;
      end else if (en_i && (cont_q != LIMITE)) begin
         cont_d = cont_q + LARGURA_TEMP'(1);
      end
   end

   always_ff @(posedge clk or negedge Nclr) begin
      if (!Nclr) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end

   assign estouro_c = en_i && !clr_i && (cont_q == LIMITE);

endmodule

// File: rtl/modulo_controlador_bandeja_rolhas.sv
// Cork tray sequencer: arbitrates sealing consumption, operator loads and
// dispenser refills onto a single saturating tray count.
module modulo_controlador_bandeja_rolhas
   import pkg_bandeja_rolhas::*;
#(
   parameter int unsigned CAP       = CAP_PADRAO,
   parameter int unsigned MIN_NIVEL = MIN_NIVEL_PADRAO,
   parameter int unsigned QTD_AUTO  = QTD_AUTO_PADRAO,
   parameter int unsigned TIMEOUT   = TIMEOUT_PADRAO
) (
   input  logic               clk,
   input  logic               Nclr,
   input  logic               enable,
   input  logic               req_vedacao,
   output logic               ack_vedacao,
   input  logic               req_carga,
   input  logic [LARGURA-1:0] qtd_carga,
   output logic               ack_carga,
   output logic               nack_carga,
   output logic               disp_req,
   input  logic               disp_ack,
   output logic [LARGURA-1:0] rolhas,
   output logic               ro,
   output logic               min_rolhas,
   output logic               falha_disp,
   output logic               ocupado
);

   localparam logic [LARGURA_SOMA-1:0] CAP_S = LARGURA_SOMA'(CAP);
   localparam logic [LARGURA_SOMA-1:0] QTD_S = LARGURA_SOMA'(QTD_AUTO);
   localparam logic [LARGURA-1:0]      MIN_R = LARGURA'(MIN_NIVEL);

   estado_e            estado_q, estado_d;
   logic [LARGURA-1:0] rolhas_q, rolhas_d;
   respostas_t         resp_q, resp_d;
   logic               disp_req_q, disp_req_d;
   logic               falha_q, falha_d;
   logic               ocupado_q, ocupado_d;
   logic               enable_q;

   logic                    vazio_c;
   logic                    min_c;
   logic                    entrega_c;
   logic                    temp_en_c;
   logic                    estouro_c;
   logic [LARGURA_SOMA-1:0] soma_c;
   logic [LARGURA-1:0]      base_c;
   logic [LARGURA_SOMA-1:0] soma_carga_c;

   assign vazio_c   = (rolhas_q == '0);
   assign min_c     = (rolhas_q < MIN_R);
   assign entrega_c = enable && disp_req_q && disp_ack;
   assign temp_en_c = enable && disp_req_q;

   // Single adder path: dispenser delivery first, then grant adjustments.
   assign soma_c       = {1'b0, rolhas_q} + (entrega_c ? QTD_S : '0);
   assign base_c       = satura(soma_c, CAP_S);
   assign soma_carga_c = {1'b0, base_c} + {1'b0, qtd_carga};

   modulo_temporizador_dispensador #(
      .TIMEOUT (TIMEOUT)
   ) u_temporizador (
      .clk       (clk),
      .Nclr      (Nclr),
      .clr_i     (!temp_en_c),
      .en_i      (temp_en_c),
      .estouro_c (estouro_c)
   );

   always_comb begin
      estado_d   = estado_q;
      rolhas_d   = enable ? base_c : rolhas_q;
      resp_d     = '0;
      disp_req_d = disp_req_q;
      falha_d    = falha_q;

      // Dispenser channel: delivery wins over a same-edge timeout.
      if (!enable) begin
         disp_req_d = 1'b0;
      end else if (entrega_c) begin
         disp_req_d = 1'b0;
      end else if (estouro_c) begin
         disp_req_d = 1'b0;
         falha_d    = 1'b1;
      end else if (min_c && !falha_q && !disp_req_q) begin
         disp_req_d = 1'b1;
      end

      if (enable_q && !enable) begin
         falha_d = 1'b0;
      end

      if (!enable) begin
         estado_d = OCIOSO;
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (req_vedacao && !vazio_c) begin
                  estado_d = VEDAR;
               end else if (req_carga) begin
                  estado_d = CARGA;
               end
            end
            VEDAR: begin
               // Decrement applied before saturation so a refill nets out once.
               rolhas_d           = satura(soma_c - LARGURA_SOMA'(!vazio_c), CAP_S);
               resp_d.ack_vedacao = 1'b1;
               estado_d           = ESPERA;
            end
            CARGA: begin
               if (soma_carga_c > CAP_S) begin
                  resp_d.nack_carga = 1'b1;
               end else begin
                  rolhas_d         = LARGURA'(soma_carga_c);
                  resp_d.ack_carga = 1'b1;
               end
               estado_d = ESPERA;
            end
            ESPERA: begin
               estado_d = OCIOSO;
            end
            default: begin
               estado_d = OCIOSO;
            end
         endcase
      end

      ocupado_d = (estado_d != OCIOSO);
   end

   always_ff @(posedge clk or negedge Nclr) begin
      if (!Nclr) begin
         estado_q   <= OCIOSO;
         rolhas_q   <= '0;
         resp_q     <= '0;
         disp_req_q <= 1'b0;
         falha_q    <= 1'b0;
         ocupado_q  <= 1'b0;
         enable_q   <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         rolhas_q   <= rolhas_d;
         resp_q     <= resp_d;
         disp_req_q <= disp_req_d;
         falha_q    <= falha_d;
         ocupado_q  <= ocupado_d;
         enable_q   <= enable;
      end
   end

   assign rolhas      = rolhas_q;
   assign ro          = vazio_c;
   assign min_rolhas  = min_c;
   assign ack_vedacao = resp_q.ack_vedacao;
   assign ack_carga   = resp_q.ack_carga;
   assign nack_carga  = resp_q.nack_carga;
   assign disp_req    = disp_req_q;
   assign falha_disp  = falha_q;
   assign ocupado     = ocupado_q;

endmodule

// File: doc/modulo_controlador_bandeja_rolhas.md
# modulo_controlador_bandeja_rolhas

Sequencer and arbiter for the cork tray buffer (0–99 corks) in the filling/sealing line. It serialises three competing updates to the tray count:
- one-cork consumption requested by the sealing stage;
- operator bulk loads;
- automatic refills from the cork dispenser.

It enforces the 0..CAP range and supervises the dispenser handshake with a timeout. It sits between the filling/sealing MEF and the tray register, and owns the count that feeds the display encoders and the cork-absence (`ro`) flag.

## Interface
- `CAP`, 99: maximum corks in tray.
- `MIN_NIVEL`, 5: auto-refill triggers when count < MIN_NIVEL.
- `QTD_AUTO`, 20: corks added per dispenser delivery.
- `TIMEOUT`, 15: cycles allowed for `disp_ack` after `disp_req` rises.
- `clk` in 1: single clock (divided system clock). All state changes on the rising edge.
- `Nclr` in 1: asynchronous, active-low reset.
- `enable` in 1: line start/stop. 0 = frozen.
- `req_vedacao` in 1: sealing stage requests one cork. Level; held until `ack_vedacao`.
- `ack_vedacao` out 1: one-cycle grant; the cork has been consumed.
- `req_carga` in 1: operator load request. Level; held until `ack_carga` or `nack_carga`.
- `qtd_carga` in 7: corks to load, 0..127. Sampled at grant.
- `ack_carga` out 1: one-cycle pulse; load applied.
- `nack_carga` out 1: one-cycle pulse; load rejected (would exceed CAP).
- `disp_req` out 1: request to the cork dispenser. Registered level.
- `disp_ack` in 1: dispenser delivered QTD_AUTO corks. Single-cycle pulse.
- `rolhas` out 7: current tray count, 0..CAP.
- `ro` out 1: combinational, `rolhas == 0`.
- `min_rolhas` out 1: combinational, `rolhas < MIN_NIVEL`.
- `falha_disp` out 1: sticky dispenser-timeout alarm.
- `ocupado` out 1: FSM not in OCIOSO.

## Operation
- FSM states and transitions:
  - OCIOSO:
    - `req_vedacao && rolhas>0` → VEDAR.
    - Else `req_carga` → CARGA.
    - Priority: sealing over load.
  - VEDAR: `rolhas` −1, `ack_vedacao`=1, → ESPERA.
  - CARGA:
    - If `rolhas + qtd_carga > CAP`: `nack_carga`=1, count unchanged.
    - Else: count += `qtd_carga`, `ack_carga`=1.
    - `qtd_carga`=0 → ack, count unchanged.
    - → ESPERA.
  - ESPERA: one-cycle turnaround; the requester drops its request on seeing ack. → OCIOSO.
- `req_vedacao` with `rolhas == 0` is not granted; it stays pending and `ro`=1 (the MEF stops on `ro`).
- Dispenser channel runs independently of the FSM:
  - `disp_req` sets when `min_rolhas && enable && !falha_disp && !disp_req`.
  - On `disp_ack` while `disp_req`: count += QTD_AUTO, saturating at CAP. `disp_req` clears.
  - `disp_ack` without `disp_req` is ignored.
- Simultaneous events in one cycle:
  - VEDAR decrement and `disp_ack` in the same cycle → net applied once: `rolhas − 1 + QTD_AUTO`, saturated at CAP.
  - CARGA and `disp_ack` in the same cycle → range check uses `rolhas + QTD_AUTO` as the base. Saturating sum, then the load is checked.
- Timeout supervision:
  - Counter runs while `disp_req`=1.
  - Reaching TIMEOUT without `disp_ack` → `disp_req` clears, `falha_disp` sets.
  - `falha_disp` clears only on `Nclr` or `enable` falling edge.
- `enable`=0:
  - FSM forced to OCIOSO; no acks/nacks; `disp_req` cleared; timeout counter cleared.
  - `rolhas` held.
- Arithmetic: internal sums 8 bits wide; `rolhas` never exceeds CAP and never wraps below 0.

## Timing
- Reset (`Nclr`=0, asynchronous):
  - State OCIOSO; `rolhas`=0; `ack_vedacao`, `ack_carga`, `nack_carga`, `disp_req`, `falha_disp`, `ocupado`=0.
  - Hence `ro`=1 and `min_rolhas`=1.
- Grant latency: request sampled in OCIOSO at edge N; ack is high during cycle N+1; new `rolhas` is visible from edge N+1. Next grant is possible at edge N+3.
- `disp_req` rises one edge after `min_rolhas` is seen true. Count updates on the edge that samples `disp_ack`.
- Timeout: `falha_disp` rises on edge TIMEOUT after `disp_req` rose.
- Reset mid-operation aborts any grant. No ack is emitted after `Nclr` is released until a new request arrives.

## Structure
- Package `pkg_bandeja_rolhas`: state enum (OCIOSO, VEDAR, CARGA, ESPERA), default CAP/MIN_NIVEL/QTD_AUTO/TIMEOUT constants, width constant 7.
- Sub-module `modulo_temporizador_dispensador`: 4-bit timeout counter with clear/enable and a `estouro` output.
- All registers in the top level with a single next-count adder/saturator path.

## Test plan
- Reset, then `enable`=1 with `rolhas`=0:
  - `ro`=1, `disp_req` rises 1 cycle later.
  - `disp_ack` → `rolhas`=20, `disp_req`=0.
- `rolhas`=20, hold `req_vedacao` 3 grants:
  - Three `ack_vedacao` pulses spaced 3 cycles apart.
  - `rolhas`=17.
- `rolhas`=90, `req_carga` with `qtd_carga`=10:
  - `nack_carga`, `rolhas`=90.
  - Retry with `qtd_carga`=9 → `ack_carga`, `rolhas`=99.
- `rolhas`=4, VEDAR coincident with `disp_ack` → `rolhas`=23.
- `rolhas`=96 with `disp_ack` → `rolhas`=99 (saturated).
- `disp_req` never acked for 15 cycles:
  - `falha_disp`=1, `disp_req`=0, no re-request.
  - Toggle `enable` 1→0→1 → `falha_disp`=0 and `disp_req` re-asserts.
